// File: rtl/fns_enc_29_seq.sv
// Sequential binary-to-FNS encoder: greedy MSB-first subtraction of Fibonacci
// weights, one codeword bit resolved per clock, valid/ready on both sides.
module fns_enc_29_seq #(
  parameter int CW = 29,
  parameter int DW = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] datain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] codeout,
  output logic          err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] remainder;
  logic [4:0]    idx;
  logic [DW-1:0] w;
  logic          take;
  logic [DW-1:0] rem_next;

  // Weight k is Fib(k+2): 1, 2, 3, 5, 8, ...
  always_comb begin
    w = '0;
    case (idx)
      5'd0:  w = DW'(32'd1);
      5'd1:  w = DW'(32'd2);
      5'd2:  w = DW'(32'd3);
      5'd3:  w = DW'(32'd5);
      5'd4:  w = DW'(32'd8);
      5'd5:  w = DW'(32'd13);
      5'd6:  w = DW'(32'd21);
      5'd7:  w = DW'(32'd34);
      5'd8:  w = DW'(32'd55);
      5'd9:  w = DW'(32'd89);
      5'd10: w = DW'(32'd144);
      5'd11: w = DW'(32'd233);
      5'd12: w = DW'(32'd377);
      5'd13: w = DW'(32'd610);
      5'd14: w = DW'(32'd987);
      5'd15: w = DW'(32'd1597);
      5'd16: w = DW'(32'd2584);
      5'd17: w = DW'(32'd4181);
      5'd18: w = DW'(32'd6765);
      5'd19: w = DW'(32'd10946);
      5'd20: w = DW'(32'd17711);
      5'd21: w = DW'(32'd28657);
      5'd22: w = DW'(32'd46368);
      5'd23: w = DW'(32'd75025);
      5'd24: w = DW'(32'd121393);
      5'd25: w = DW'(32'd196418);
      5'd26: w = DW'(32'd317811);
      5'd27: w = DW'(32'd514229);
      5'd28: w = DW'(32'd832040);
      default: w = '0;
    endcase
  end

  always_comb begin
    take     = (remainder >= w);
    rem_next = take ? (remainder - w) : remainder;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remainder <= '0;
      idx       <= 5'd28;
      codeout   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            remainder <= datain;
            codeout   <= '0;
            err       <= 1'b0;
            idx       <= 5'd28;
            state     <= RUN;
          end
        end
        RUN: begin
          codeout[idx] <= take;
          remainder    <= rem_next;
          if (idx == 5'd0) begin
            err   <= (rem_next != '0);
            state <= DONE;
          end else begin
            idx <= idx - 5'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fns_enc_29_seq.md
Name: fns_enc_29_seq

Overview:
- Sequential binary-to-FNS encoder for the 29-bit Fibonacci-numeral codeword path.
- Sits directly upstream of the 29-bit FNS decoder stage and produces the 29-bit codeword that the decoder consumes.
- Converts a `FBLEN29-bit binary word by greedy MSB-first subtraction of the FNS weights from FNS.vh, resolving one codeword bit per clock.
- Uses valid/ready handshakes on both input and output.

Parameters:
- CW, 29: codeword width. Fixed; the weight table covers exactly 29 entries.
- DW, `FBLEN29: binary data width, shared with the decoder output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  datain is valid.
- in_ready  out  1  encoder can accept a word.
- datain  in  DW  binary value to encode.
- out_valid  out  1  codeout and err are valid.
- out_ready  in  1  downstream accepts codeout.
- codeout  out  CW  FNS codeword; bit k has weight `FNS(k+1), so bit 0 is `FNS01 and bit 28 is `FNS29.
- err  out  1  input was not representable; the remainder was nonzero after bit 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, codeout=0, err=0, remainder=0, idx=28.
- Reset mid-conversion aborts the conversion. No partial result is emitted.
- Weight lookup: combinational 29:1 mux of `FNS01..`FNS29, indexed by idx. All arithmetic is unsigned at DW bits.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: remainder<=datain, codeout<=0, err<=0, idx<=28, go to RUN.
- RUN (in_ready=0, out_valid=0), one bit per cycle:
  - If remainder >= W[idx]: codeout[idx]<=1 and remainder<=remainder-W[idx]. Otherwise codeout[idx]<=0.
  - If idx==0: err<=(remainder_next!=0), go to DONE. Otherwise idx<=idx-1.
- DONE:
  - out_valid=1, codeout and err held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - No bypass: in_ready rises the cycle after the output handshake.
- Latency: accept edge = cycle 0; bits 28..0 resolve on edges 1..29; out_valid is high after edge 29.
- Throughput: one word per 31 cycles when out_ready is held high.
- out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored; the source must hold its word until accepted.
- datain is sampled only at the accept edge. Later changes to datain do not affect the conversion.
- Greedy encoding of in-range inputs yields no two adjacent 1s, i.e. a valid FNS codeword for the decoder.
- Round-trip guarantee: decoder(codeout) equals datain whenever err=0.
- When err=1, codeout still holds the greedy result, and the decoded value is less than datain.

Test Plan:
1. After reset: in_ready=1, out_valid=0, codeout=0, err=0. Then datain=0 accepted -> after edge 29, out_valid=1, codeout=29'h0, err=0.
2. datain=`FNS29 -> codeout=29'h1000_0000, err=0. datain=`FNS05+`FNS03 -> codeout=29'h0000_0014, err=0.
3. Random in-range datain (≥1000 words) with out_ready=1 -> feed codeout into the FNS_dec_29 model; decoded value==datain, no adjacent 1s in codeout, err=0, accept-to-out_valid = 29 cycles.
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> codeout and err stable, in_ready=0 throughout, datain changes ignored. Raise out_ready -> out_valid drops next edge, in_ready=1 the following cycle.
5. Out-of-range: only if 2^DW-1 exceeds the sum of `FNS01..`FNS29, datain=all ones -> err=1 and codeout=29'h1555_5555; otherwise this case is skipped.
6. Assert rst_n low asynchronously at cycle 12 of RUN -> outputs clear immediately to reset values, no out_valid pulse. The next word then encodes correctly.
